// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, ALU, iterative mul/div unit,
// data SRAM request and the EX/MEM and forwarding buses.
module ex_stage #(
  parameter int STALL_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic [145:0]       id_to_ex_bus,
  output logic [75:0]        ex_to_mem_bus,
  output logic [37:0]        ex_to_id_bus,
  output logic               data_sram_en,
  output logic [3:0]         data_sram_wen,
  output logic [31:0]        data_sram_addr,
  output logic [31:0]        data_sram_wdata,
  output logic               stallreq_for_ex
);

  localparam logic STOP = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [1:0]  md_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] store_data;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } md_state_t;

  localparam logic [1:0] MD_MUL = 2'b01;
  localparam logic [1:0] MD_DIV = 2'b10;

  id_ex_t      id_r;
  md_state_t   state;
  md_state_t   state_n;
  logic [4:0]  cnt;
  logic [1:0]  op_r;
  logic [31:0] x_r;
  logic [31:0] y_r;
  logic [31:0] z_r;
  logic [31:0] x_n;
  logic [31:0] y_n;
  logic [31:0] z_n;
  logic [31:0] md_res;
  logic [31:0] alu_res;
  logic [31:0] ex_result;
  logic [32:0] trial;
  logic [32:0] diff;
  logic        fits;
  logic        ex_stop;
  logic        mem_stop;
  logic        md_req;
  logic        unused;

  assign ex_stop  = stall[2] == STOP;
  assign mem_stop = stall[3] == STOP;
  assign md_req   = id_r.md_op != 2'b00;
  assign unused   = ^stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_r <= '0;
    end else if (ex_stop && !mem_stop) begin
      id_r <= '0;
    end else if (!ex_stop) begin
      id_r <= id_to_ex_bus;
    end
  end

  logic [4:0] sh;
  assign sh = id_r.src1[4:0];

  always_comb begin
    alu_res = '0;
    unique case (id_r.alu_op)
      4'd0:  alu_res = id_r.src1 + id_r.src2;
      4'd1:  alu_res = id_r.src1 - id_r.src2;
      4'd2:  alu_res = id_r.src1 & id_r.src2;
      4'd3:  alu_res = id_r.src1 | id_r.src2;
      4'd4:  alu_res = id_r.src1 ^ id_r.src2;
      4'd5:  alu_res = ~(id_r.src1 | id_r.src2);
      4'd6:  alu_res = {31'd0, $signed(id_r.src1) < $signed(id_r.src2)};
      4'd7:  alu_res = {31'd0, id_r.src1 < id_r.src2};
      4'd8:  alu_res = id_r.src2 << sh;
      4'd9:  alu_res = id_r.src2 >> sh;
      4'd10: alu_res = $unsigned($signed(id_r.src2) >>> sh);
      4'd11: alu_res = {id_r.src2[15:0], 16'h0};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n         = state;
    stallreq_for_ex = 1'b0;
    unique case (state)
      IDLE: begin
        if (md_req) begin
          state_n         = BUSY;
          stallreq_for_ex = 1'b1;
        end
      end
      BUSY: begin
        stallreq_for_ex = 1'b1;
        if (cnt == 5'd31) state_n = DONE;
      end
      DONE: begin
        if (!ex_stop) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // x: accumulator / partial remainder
  // y: multiplier / dividend shifting into quotient
  // z: multiplicand / divisor
  assign trial = {x_r, y_r[31]};
  assign diff  = trial - {1'b0, z_r};
  assign fits  = trial >= {1'b0, z_r};

  always_comb begin
    x_n = x_r;
    y_n = y_r;
    z_n = z_r;
    if (op_r == MD_MUL) begin
      x_n = x_r + (y_r[0] ? z_r : 32'd0);
      y_n = y_r >> 1;
      z_n = z_r << 1;
    end else begin
      x_n = fits ? diff[31:0] : trial[31:0];
      y_n = {y_r[30:0], fits};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      op_r   <= '0;
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
      md_res <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (md_req) begin
            cnt  <= '0;
            op_r <= id_r.md_op;
            x_r  <= '0;
            y_r  <= (id_r.md_op == MD_MUL) ? id_r.src2 : id_r.src1;
            z_r  <= (id_r.md_op == MD_MUL) ? id_r.src1 : id_r.src2;
          end
        end
        BUSY: begin
          cnt <= cnt + 5'd1;
          x_r <= x_n;
          y_r <= y_n;
          z_r <= z_n;
          if (cnt == 5'd31) md_res <= (op_r == MD_DIV) ? y_n : x_n;
        end
        default: ;
      endcase
    end
  end

  assign ex_result = md_req ? md_res : alu_res;

  assign data_sram_en    = id_r.data_ram_en;
  assign data_sram_wen   = id_r.data_ram_wen;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = id_r.store_data;

  ex_mem_t mem_b;

  always_comb begin
    mem_b.pc           = id_r.pc;
    mem_b.data_ram_en  = id_r.data_ram_en;
    mem_b.data_ram_wen = id_r.data_ram_wen;
    mem_b.sel_rf_res   = id_r.sel_rf_res;
    mem_b.rf_we        = id_r.rf_we;
    mem_b.rf_waddr     = id_r.rf_waddr;
    mem_b.ex_result    = ex_result;
  end

  assign ex_to_mem_bus = mem_b;
  assign ex_to_id_bus  = {id_r.rf_we, id_r.rf_waddr, ex_result};

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against an arithmetic reference model;
// the bench also plays the stall controller.
module tb_ex_stage;

  logic         clk;
  logic         rst;
  logic [5:0]   stall;
  logic [5:0]   stall_drv;
  logic [145:0] bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_id_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         stallreq;

  int n_chk = 0;
  int n_err = 0;

  ex_stage #(.STALL_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .id_to_ex_bus(bus),
    .ex_to_mem_bus(ex_to_mem_bus),
    .ex_to_id_bus(ex_to_id_bus),
    .data_sram_en(data_sram_en),
    .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .stallreq_for_ex(stallreq)
  );

  // stall controller: a mul/div request freezes EX and MEM registers
  assign stall = stallreq ? 6'b001111 : stall_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [75:0] got,
                     input logic [75:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [145:0] mk(
    input logic [31:0] pc, input logic [3:0] op, input logic [1:0] md,
    input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
    input logic en, input logic [3:0] wen, input logic sel,
    input logic we, input logic [4:0] wa);
    return {pc, op, md, a, b, sd, en, wen, sel, we, wa};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned s;
    logic [31:0] ones;
    s = a % 32;
    ones = 32'hFFFF_FFFF;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a + (~b + 32'd1);
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      4'd7:  return {31'd0, a < b};
      4'd8:  return b << s;
      4'd9:  return b >> s;
      4'd10: return (b >> s) | (b[31] ? ~(ones >> s) : 32'd0);
      4'd11: return b * 32'd65536;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [1:0] md,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    case (md)
      2'b01:   return p[31:0];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic run_alu(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    logic [31:0] pc;
    logic [31:0] sd;
    logic [31:0] r;
    logic [4:0]  wa;
    logic [3:0]  wen;
    logic        en;
    logic        sel;
    logic        we;
    pc  = $urandom;
    sd  = $urandom;
    wa  = 5'($urandom);
    wen = 4'($urandom);
    en  = 1'($urandom);
    sel = 1'($urandom);
    we  = 1'($urandom);
    @(negedge clk);
    stall_drv = '0;
    bus = mk(pc, op, 2'b00, a, b, sd, en, wen, sel, we, wa);
    @(posedge clk);
    #1;
    r = ref_alu(op, a, b);
    chk("alu_mem_bus", ex_to_mem_bus, {pc, en, wen, sel, we, wa, r});
    chk("alu_fwd_bus", ex_to_id_bus, {we, wa, r});
    chk("alu_addr", data_sram_addr, r);
    chk("alu_wdata", data_sram_wdata, sd);
    chk("alu_en_wen", {data_sram_en, data_sram_wen}, {en, wen});
    chk("alu_no_stall", stallreq, 1'b0);
  endtask

  task automatic run_md(input logic [1:0] md, input logic [31:0] a,
                        input logic [31:0] b, input bit hold);
    int n;
    logic [31:0] r;
    @(negedge clk);
    stall_drv = '0;
    bus = mk(32'h400, 4'd0, md, a, b, 32'd0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd9);
    @(posedge clk);
    #1;
    bus = mk(32'h404, 4'd0, 2'b00, a, 32'd1, 32'd0,
             1'b0, 4'd0, 1'b0, 1'b1, 5'd10);
    n = 0;
    while (stallreq && n < 60) begin
      n++;
      @(posedge clk);
      #1;
    end
    r = ref_md(md, a, b);
    chk("md_stall_cycles", n, 33);
    chk("md_result", ex_to_mem_bus[31:0], r);
    chk("md_pc", ex_to_mem_bus[75:44], 32'h400);
    if (hold) begin
      stall_drv = 6'b001111;
      repeat (3) @(posedge clk);
      #1;
      chk("md_hold_result", ex_to_mem_bus[31:0], r);
      chk("md_hold_no_stall", stallreq, 1'b0);
      stall_drv = '0;
    end
    @(posedge clk);
    #1;
    chk("md_next_result", ex_to_mem_bus[31:0], a + 32'd1);
    chk("md_next_pc", ex_to_mem_bus[75:44], 32'h404);
    chk("md_next_no_stall", stallreq, 1'b0);
  endtask

  initial begin
    logic [31:0] sd;
    rst = 1'b1;
    stall_drv = '0;
    bus = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_bus", ex_to_mem_bus, 76'd0);
    chk("rst_fwd_bus", ex_to_id_bus, 38'd0);
    chk("rst_sram", {data_sram_en, data_sram_wen, data_sram_addr,
                     data_sram_wdata}, 69'd0);
    chk("rst_stall", stallreq, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_alu(4'd0, 32'h7FFF_FFFF, 32'd1);
    run_alu(4'd10, 32'd4, 32'h8000_0000);
    run_alu(4'd7, 32'd1, 32'hFFFF_FFFF);
    run_alu(4'd6, 32'hFFFF_FFFF, 32'd1);
    run_alu(4'd11, 32'd0, 32'h0000_ABCD);
    for (int i = 0; i < 40; i++)
      run_alu(4'($urandom_range(0, 15)), $urandom, $urandom);

    sd = $urandom;
    @(negedge clk);
    bus = mk(32'h200, 4'd0, 2'b00, 32'h1000, 32'd8, sd,
             1'b1, 4'hF, 1'b0, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    chk("st_addr", data_sram_addr, 32'h1008);
    chk("st_wdata", data_sram_wdata, sd);
    chk("st_en_wen", {data_sram_en, data_sram_wen}, 5'h1F);
    @(negedge clk);
    stall_drv = 6'b000111;
    bus = mk(32'h204, 4'd0, 2'b01, 32'h3, 32'd5, 32'd7,
             1'b1, 4'h3, 1'b1, 1'b1, 5'd3);
    @(posedge clk);
    #1;
    chk("bubble_en_wen", {data_sram_en, data_sram_wen}, 5'h00);
    chk("bubble_mem_bus", ex_to_mem_bus, 76'd0);
    chk("bubble_no_stall", stallreq, 1'b0);
    stall_drv = '0;

    run_md(2'b01, 32'h1_0000, 32'h1_0003, 1'b1);
    run_md(2'b10, 32'd100, 32'd7, 1'b0);
    run_md(2'b11, 32'd100, 32'd7, 1'b0);
    run_md(2'b10, 32'd5, 32'd0, 1'b0);
    run_md(2'b11, 32'd5, 32'd0, 1'b1);
    for (int i = 0; i < 6; i++)
      run_md(2'($urandom_range(1, 3)), $urandom,
             (i == 0) ? 32'($urandom_range(1, 9)) : $urandom, 1'b0);

    @(negedge clk);
    bus = mk(32'h600, 4'd0, 2'b10, 32'hDEAD_BEEF, 32'd3, 32'h55,
             1'b1, 4'h1, 1'b0, 1'b1, 5'd4);
    @(posedge clk);
    repeat (10) @(posedge clk);
    #3;
    bus = '0;
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", stallreq, 1'b0);
    chk("mid_rst_mem_bus", ex_to_mem_bus, 76'd0);
    chk("mid_rst_fwd_bus", ex_to_id_bus, 38'd0);
    chk("mid_rst_sram", {data_sram_en, data_sram_wen, data_sram_addr,
                         data_sram_wdata}, 69'd0);
    @(negedge clk);
    rst = 1'b0;
    run_alu(4'd0, 32'd40, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
